// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles every handshake and bus signal around the data-memory arbiter:
//   the two requester ports (fetch = port 0, load/store = port 1) and the
//   strobe-style link to the wait-state memory.
//   modport slave  : the arbiter (consumes requests, drives the memory bus)
//   modport master : the environment (requesters plus the memory's read data)
`timescale 1ns/1ps

interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // requester side
    logic          req0;
    logic          req1;
    logic          rw0;
    logic          rw1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          done0;
    logic          done1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          busy;
    logic          gnt;

    // memory side
    logic          mstrobe;
    logic          mem_r_w;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_out;

    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_out,
        output done0, done1, rdata0, rdata1, busy, gnt,
               mstrobe, mem_r_w, mem_addr, mem_data
    );

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_out,
        input  done0, done1, rdata0, rdata1, busy, gnt,
               mstrobe, mem_r_w, mem_addr, mem_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one wait-state data memory between two requesters. Each granted
//   request becomes a single-cycle mstrobe followed by a fixed wait period,
//   during which address, data and direction are held; the requester then
//   gets a one-cycle done pulse and, for reads, the captured data.
//
//   Parameters
//     LATENCY : memory wait cycles after the strobe (1..15)
//     AW, DW  : address / data width
//   Ports
//     clk     : clock, rising edge
//     reset_n : synchronous, active-low reset
//     bus     : dmem_arbiter_if.slave -- requester ports 0/1, status
//               (busy, gnt) and the memory bus (mstrobe, mem_r_w,
//               mem_addr, mem_data, mem_out)
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int LATENCY = 4,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    dmem_arbiter_if.slave bus
);

    // The counter is loaded on leaving STROBE and counts down to zero, so
    // the FSM spends exactly LATENCY cycles in WAIT.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_reg;
    logic [3:0]    cnt_reg;
    logic          last_reg;        // port served by the most recent grant
    logic          gnt_reg;
    logic          busy_reg;
    logic          mstrobe_reg;
    logic          mem_r_w_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_data_reg;
    logic [1:0]    done_reg;
    logic [DW-1:0] rdata_reg [2];

    // Per-port views of the request inputs so the grant can index them.
    logic [1:0]    req;
    logic [1:0]    rw;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    assign req      = {bus.req1, bus.req0};
    assign rw       = {bus.rw1, bus.rw0};
    assign addr[0]  = bus.addr0;
    assign addr[1]  = bus.addr1;
    assign wdata[0] = bus.wdata0;
    assign wdata[1] = bus.wdata1;

    // ------------------------------------------------------------------
    // Round-robin pick: a lone requester always wins; on a tie the port
    // that was not served last goes first.
    // ------------------------------------------------------------------
    logic pick;

    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) begin
            pick = ~last_reg;
        end else if (req[1]) begin
            pick = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer. All outputs are registered here; requests are only looked
    // at in IDLE, so anything raised while busy simply waits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            last_reg     <= 1'b1;       // port 0 wins the first tie
            gnt_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            mstrobe_reg  <= 1'b0;
            mem_r_w_reg  <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            done_reg     <= 2'b00;
        end else begin
            // strobe and done are single-cycle pulses
            mstrobe_reg <= 1'b0;
            done_reg    <= 2'b00;

            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        gnt_reg      <= pick;
                        last_reg     <= pick;
                        mem_r_w_reg  <= rw[pick];
                        mem_addr_reg <= addr[pick];
                        mem_data_reg <= wdata[pick];
                        mstrobe_reg  <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= STROBE;
                    end
                end

                STROBE: begin
                    cnt_reg   <= CNT_LOAD;
                    state_reg <= WAIT;
                end

                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        done_reg[gnt_reg] <= 1'b1;
                        state_reg         <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end

                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-data capture on the edge that enters DONE. Only the granted
    // port's register moves, and only for reads; the other port's value
    // is left alone.
    // ------------------------------------------------------------------
    logic capture;

    assign capture = (state_reg == WAIT) && (cnt_reg == 4'd0) && !mem_r_w_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rdata_reg[gi] <= '0;
                end else if (capture && (gnt_reg == 1'(gi))) begin
                    rdata_reg[gi] <= bus.mem_out;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.done0    = done_reg[0];
    assign bus.done1    = done_reg[1];
    assign bus.rdata0   = rdata_reg[0];
    assign bus.rdata1   = rdata_reg[1];
    assign bus.busy     = busy_reg;
    assign bus.gnt      = gnt_reg;
    assign bus.mstrobe  = mstrobe_reg;
    assign bus.mem_r_w  = mem_r_w_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.mem_data = mem_data_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter (LATENCY = 4). Stimulus pushes the
//   expected completions (port, read data, edge at which done shows) into
//   a scoreboard queue; a monitor on the falling edge pops and compares on
//   every done pulse and also watches strobe width and bus stability.
//   cyc counts rising edges: a request driven at a falling edge with
//   cyc == c is sampled at edge c+1 and its done is visible after edge c+6.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic preload;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.LATENCY(LAT), .AW(32), .DW(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Small stand-in for the wait-state memory: writes land on the strobe,
    // reads are presented from the held address.
    logic [31:0] mem [64];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 8) ? 32'h302fcaaa : 32'h0;
        end else if (bus.mstrobe && bus.mem_r_w) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_data;
        end
    end

    assign bus.mem_out = mem[bus.mem_addr[7:2]];

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int port, input logic [31:0] data, input int at);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic        prev_strobe = 1'b0;
    logic        in_txn = 1'b0;
    logic [31:0] snap_addr, snap_data;
    logic        snap_rw;

    always @(negedge clk) begin : mon
        exp_t        e;
        logic        d;
        logic [31:0] rd;
        if (reset_n === 1'b1) begin
            if (bus.mstrobe) begin
                chk("strobe_single", prev_strobe, 1'b0);
                snap_addr = bus.mem_addr;
                snap_data = bus.mem_data;
                snap_rw   = bus.mem_r_w;
                in_txn    = 1'b1;
            end else if (in_txn && bus.busy && !bus.done0 && !bus.done1) begin
                chk("hold_addr", bus.mem_addr, snap_addr);
                chk("hold_data", bus.mem_data, snap_data);
                chk("hold_rw",   bus.mem_r_w,  snap_rw);
            end
            prev_strobe = bus.mstrobe;

            for (int p = 0; p < 2; p++) begin
                d  = (p == 0) ? bus.done0 : bus.done1;
                rd = (p == 0) ? bus.rdata0 : bus.rdata1;
                if (d) begin
                    in_txn = 1'b0;
                    $display("txn done port=%0d rdata=%08h gnt=%0d cyc=%0d", p, rd, bus.gnt, cyc);
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1'b1, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_port",  p,       e.port);
                        chk("done_rdata", rd,      e.data);
                        chk("done_cycle", cyc,     e.cyc);
                        chk("done_gnt",   bus.gnt, e.port);
                    end
                end
            end
        end else begin
            prev_strobe = 1'b0;
            in_txn      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic wait_done(input int p);
        for (int i = 0; i < 40; i++) begin
            if (((p == 0) ? bus.done0 : bus.done1) === 1'b1) return;
            @(negedge clk);
        end
        chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_mstrobe"},  bus.mstrobe,  1'b0);
        chk({tag, "_mem_r_w"},  bus.mem_r_w,  1'b0);
        chk({tag, "_done0"},    bus.done0,    1'b0);
        chk({tag, "_done1"},    bus.done1,    1'b0);
        chk({tag, "_busy"},     bus.busy,     1'b0);
        chk({tag, "_gnt"},      bus.gnt,      1'b0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, "_mem_data"}, bus.mem_data, 32'h0);
        chk({tag, "_rdata0"},   bus.rdata0,   32'h0);
        chk({tag, "_rdata1"},   bus.rdata1,   32'h0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int c;
        bus.req0 = 1'b0; bus.rw0 = 1'b0; bus.addr0 = 32'h20; bus.wdata0 = 32'h0;
        bus.req1 = 1'b0; bus.rw1 = 1'b0; bus.addr1 = 32'h24; bus.wdata1 = 32'h0;
        reset_n = 1'b0;
        preload = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        check_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // 1: single read from port 0
        c = cyc;
        bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 32'h20;
        push(0, 32'h302fcaaa, c + 6);
        @(negedge clk);
        chk("t1_strobe", bus.mstrobe, 1'b1);
        chk("t1_mem_addr", bus.mem_addr, 32'h20);
        chk("t1_busy", bus.busy, 1'b1);
        @(negedge clk);
        chk("t1_strobe_low", bus.mstrobe, 1'b0);
        wait_done(0);
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("t1_busy_low", bus.busy, 1'b0);

        // 2: port 1 write then read back
        c = cyc;
        bus.req1 = 1'b1; bus.rw1 = 1'b1; bus.addr1 = 32'h24; bus.wdata1 = 32'hdeadbeef;
        push(1, 32'h0, c + 6);                  // rdata1 untouched by a write
        @(negedge clk);
        chk("t2_mem_r_w", bus.mem_r_w, 1'b1);
        chk("t2_mem_data", bus.mem_data, 32'hdeadbeef);
        wait_done(1);
        bus.req1 = 1'b0;
        @(negedge clk);
        c = cyc;
        bus.req1 = 1'b1; bus.rw1 = 1'b0;
        push(1, 32'hdeadbeef, c + 6);
        wait_done(1);
        bus.req1 = 1'b0;
        @(negedge clk);

        // 3: tie straight after reset, port 0 first
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        c = cyc;
        bus.req0 = 1'b1; bus.rw0 = 1'b0; bus.addr0 = 32'h20;
        bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 32'h24;
        push(0, 32'h302fcaaa, c + 6);
        push(1, 32'hdeadbeef, c + 13);
        wait_done(0);
        bus.req0 = 1'b0;
        wait_done(1);
        chk("t3_rdata0_held", bus.rdata0, 32'h302fcaaa);
        bus.req1 = 1'b0;
        @(negedge clk);

        // 4: both held for four transactions, grants alternate
        c = cyc;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        push(0, 32'h302fcaaa, c + 6);
        push(1, 32'hdeadbeef, c + 13);
        push(0, 32'h302fcaaa, c + 20);
        push(1, 32'hdeadbeef, c + 27);
        wait_until(c + 27);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge clk);

        // 5: reset during the second WAIT cycle of a read
        c = cyc;
        bus.req0 = 1'b1;
        wait_until(c + 3);
        reset_n  = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        check_reset("t5");
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_idle_busy", bus.busy, 1'b0);
        c = cyc;
        bus.req0 = 1'b1;
        push(0, 32'h302fcaaa, c + 6);
        wait_done(0);
        bus.req0 = 1'b0;
        @(negedge clk);

        // 6a: req0 still high after done starts a second port-0 transaction
        c = cyc;
        bus.req0 = 1'b1; bus.addr0 = 32'h20;
        push(0, 32'h302fcaaa, c + 6);
        wait_until(c + 7);
        bus.addr0 = 32'h24;
        push(0, 32'hdeadbeef, c + 13);
        wait_until(c + 13);
        bus.req0 = 1'b0;
        @(negedge clk);
        bus.addr0 = 32'h20;

        // 6b: same, but req1 also up at that IDLE edge -> port 1 wins
        c = cyc;
        bus.req0 = 1'b1;
        push(0, 32'h302fcaaa, c + 6);
        wait_until(c + 7);
        bus.req1 = 1'b1; bus.rw1 = 1'b0; bus.addr1 = 32'h24;
        push(1, 32'hdeadbeef, c + 13);
        push(0, 32'h302fcaaa, c + 20);
        wait_until(c + 13);
        bus.req1 = 1'b0;
        wait_until(c + 20);
        bus.req0 = 1'b0;

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
